// File: rtl/cgra_data_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cgra_data_bus_ctrl
// Purpose  : Per-column data-bus master between the RC column data ports and
//            the system bus. Strided read/write pointers, byte/half/word
//            accesses with byte enables, read alignment and extension, and
//            grouped stall merging across columns.
// Options  : define CGRA_DBUS_TIMEOUT_EN to build the read-response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module cgra_data_bus_ctrl #(
   parameter int N_COL          = 4,
   parameter int MAX_COL_REQ    = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [N_COL-1:0]                  col_start_i,
   input  logic [N_COL-1:0]                  col_conf_ack_i,
   input  logic [N_COL*N_COL-1:0]            col_acc_map_i,
   input  logic [MAX_COL_REQ*ADDR_WIDTH-1:0] rd_ptr_i,
   input  logic [MAX_COL_REQ*ADDR_WIDTH-1:0] wr_ptr_i,
   input  logic [MAX_COL_REQ*ADDR_WIDTH-1:0] stride_i,
   input  logic [N_COL-1:0]                  rcs_req_i,
   input  logic [N_COL-1:0]                  rcs_wen_i,
   input  logic [N_COL-1:0]                  rcs_ind_i,
   input  logic [N_COL-1:0]                  rcs_sext_i,
   input  logic [2*N_COL-1:0]                rcs_size_i,
   input  logic [N_COL*DATA_WIDTH-1:0]       rcs_add_i,
   input  logic [N_COL*DATA_WIDTH-1:0]       rcs_wdata_i,
   output logic [N_COL-1:0]                  bus_req_o,
   output logic [N_COL-1:0]                  bus_wen_o,
   output logic [N_COL*ADDR_WIDTH-1:0]       bus_add_o,
   output logic [N_COL*DATA_WIDTH-1:0]       bus_wdata_o,
   output logic [4*N_COL-1:0]                bus_be_o,
   input  logic [N_COL-1:0]                  bus_gnt_i,
   input  logic [N_COL-1:0]                  bus_rvalid_i,
   input  logic [N_COL*DATA_WIDTH-1:0]       bus_rdata_i,
   output logic [N_COL*DATA_WIDTH-1:0]       rcs_rdata_o,
   output logic [N_COL-1:0]                  rcs_rvalid_o,
   output logic [N_COL-1:0]                  data_stall_o,
   output logic [2*N_COL-1:0]                err_o
);

   localparam int SET_W = (MAX_COL_REQ > 1) ? $clog2(MAX_COL_REQ) : 1;

   typedef enum logic [0:0] {
      ST_ADDR = 1'b0,
      ST_DATA = 1'b1
   } state_e;

   // A watchdog limit below 2 cannot be honoured by the counter; such a
   // configuration elaborates this empty marker block.
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_cfg_invalid
   end

   // Lane shift followed by zero/sign extension of the returned word.
   function automatic logic [31:0] align_ext(input logic [31:0] d,
                                             input logic [1:0]  off,
                                             input logic [1:0]  sz,
                                             input logic        sx);
      logic [31:0] sh;
      sh = d >> {off, 3'b000};
      case (sz)
         2'b00:   align_ext = {{24{sx & sh[7]}}, sh[7:0]};
         2'b01:   align_ext = {{16{sx & sh[15]}}, sh[15:0]};
         default: align_ext = sh;
      endcase
   endfunction

   logic [SET_W-1:0] set_sel;
   int               ack_cnt;
   logic [N_COL-1:0] stall_s;

   // Pointer-set index: number of acknowledging columns, saturated.
   always_comb begin
      ack_cnt = 0;
      for (int k = 0; k < N_COL; k++) ack_cnt = ack_cnt + int'(col_conf_ack_i[k]);
      if (ack_cnt > MAX_COL_REQ - 1) ack_cnt = MAX_COL_REQ - 1;
      set_sel = SET_W'(ack_cnt);
   end

   assign rcs_rvalid_o = bus_rvalid_i;
   assign bus_wen_o    = rcs_wen_i;

   for (genvar c = 0; c < N_COL; c++) begin : g_col
      state_e                state_q, state_d;
      logic [ADDR_WIDTH-1:0] rd_ptr_q, wr_ptr_q;
      logic [SET_W-1:0]      set_q;
      logic [1:0]            off_q, size_q;
      logic                  sext_q;
      logic [31:0]           hold_q;
      logic [1:0]            err_q;

      logic [ADDR_WIDTH-1:0] addr, stride;
      logic [1:0]            size;
      logic [31:0]           wdata, wd, rdata_al;
      logic [3:0]            be;
      logic                  mis, issue, gnt, rv_ok, tmo;

      assign size   = rcs_size_i[2*c +: 2];
      assign wdata  = rcs_wdata_i[c*DATA_WIDTH +: 32];
      assign stride = stride_i[set_q*ADDR_WIDTH +: ADDR_WIDTH];
      assign addr   = rcs_ind_i[c] ? ADDR_WIDTH'(rcs_add_i[c*DATA_WIDTH +: DATA_WIDTH]) :
                      (rcs_wen_i[c] ? rd_ptr_q : wr_ptr_q);
      // In DATA a new request may only go out alongside the pending response.
      assign issue  = rcs_req_i[c] & ((state_q == ST_ADDR) | bus_rvalid_i[c]);
      assign gnt    = issue & bus_gnt_i[c];
      assign rv_ok  = (state_q == ST_DATA) & bus_rvalid_i[c];
      assign rdata_al = align_ext(bus_rdata_i[c*DATA_WIDTH +: 32], off_q, size_q, sext_q);

`ifdef CGRA_DBUS_TIMEOUT_EN
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
      logic [TW-1:0] wdog_q;
      assign tmo = (state_q == ST_DATA) & ~bus_rvalid_i[c] &
                   (wdog_q == TW'(TIMEOUT_CYCLES - 1));
      // Watchdog counts waiting DATA cycles; zero outside DATA and on response.
      always_ff @(posedge clk_i) begin
         if (rst_i || state_q != ST_DATA || rv_ok || tmo) wdog_q <= '0;
         else                                             wdog_q <= wdog_q + 1'b1;
      end
`else
      assign tmo = 1'b0;
`endif

      // Byte enables, lane replication and alignment check for this access.
      always_comb begin
         mis = 1'b0;
         be  = 4'b1111;
         wd  = wdata;
         case (size)
            2'b00: begin
               be = 4'b0001 << addr[1:0];
               wd = {4{wdata[7:0]}};
            end
            2'b01: begin
               wd = {2{wdata[15:0]}};
               if (addr[0]) mis = 1'b1;
               else         be  = 4'b0011 << addr[1:0];
            end
            default: mis = (addr[1:0] != 2'b00);
         endcase
         if (!issue) be = 4'b1111;
      end

      // Next state: response or watchdog ends DATA, a read grant (re)enters it.
      always_comb begin
         state_d = state_q;
         if (state_q == ST_DATA && (rv_ok || tmo)) state_d = ST_ADDR;
         if (gnt && rcs_wen_i[c])                  state_d = ST_DATA;
      end

      // State, data-phase attributes, hold register, pointers and errors.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q  <= ST_ADDR;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            set_q    <= '0;
            off_q    <= '0;
            size_q   <= '0;
            sext_q   <= 1'b0;
            hold_q   <= '0;
            err_q    <= '0;
         end else begin
            state_q <= state_d;
            if (gnt && rcs_wen_i[c]) begin
               off_q  <= addr[1:0];
               size_q <= size;
               sext_q <= rcs_sext_i[c];
            end
            if (rv_ok)    hold_q <= rdata_al;
            else if (tmo) hold_q <= '0;
            if (col_start_i[c]) begin
               rd_ptr_q <= rd_ptr_i[set_sel*ADDR_WIDTH +: ADDR_WIDTH];
               wr_ptr_q <= wr_ptr_i[set_sel*ADDR_WIDTH +: ADDR_WIDTH];
               set_q    <= set_sel;
               err_q    <= '0;
            end else begin
               if (gnt && !rcs_ind_i[c]) begin
                  if (rcs_wen_i[c]) rd_ptr_q <= rd_ptr_q + stride;
                  else              wr_ptr_q <= wr_ptr_q + stride;
               end
               if (gnt && mis) err_q[0] <= 1'b1;
               if (tmo)        err_q[1] <= 1'b1;
            end
         end
      end

      assign stall_s[c]                      = issue | (state_d == ST_DATA);
      assign bus_req_o[c]                    = issue;
      assign bus_add_o[c*ADDR_WIDTH +: ADDR_WIDTH] = {addr[ADDR_WIDTH-1:2], 2'b00};
      assign bus_be_o[4*c +: 4]              = be;
      assign bus_wdata_o[c*DATA_WIDTH +: 32] = wd;
      assign rcs_rdata_o[c*DATA_WIDTH +: 32] = rv_ok ? rdata_al : hold_q;
      assign err_o[2*c +: 2]                 = err_q;
   end

   for (genvar j = 0; j < N_COL; j++) begin : g_stall
      assign data_stall_o[j] = |(stall_s & col_acc_map_i[j*N_COL +: N_COL]);
   end

endmodule
`default_nettype wire

// File: tb/tb_cgra_data_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cgra_data_bus_ctrl
// Purpose  : Scoreboard bench for cgra_data_bus_ctrl (directed + random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cgra_data_bus_ctrl;
   localparam int NC = 4;

   typedef struct packed {
      logic [31:0] add;
      logic [3:0]  be;
      logic        wen;
      logic [31:0] wd;
   } bus_t;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [3:0]    col_start, col_conf_ack;
   logic [15:0]   acc_map;
   logic [127:0]  rd_ptr, wr_ptr, stride;
   logic [3:0]    rcs_req, rcs_wen, rcs_ind, rcs_sext;
   logic [7:0]    rcs_size;
   logic [127:0]  rcs_add, rcs_wdata;
   logic [3:0]    bus_req_o, bus_wen_o;
   logic [127:0]  bus_add_o, bus_wdata_o;
   logic [15:0]   bus_be_o;
   logic [3:0]    bus_gnt, bus_rvalid;
   logic [127:0]  bus_rdata;
   logic [127:0]  rcs_rdata_o;
   logic [3:0]    rcs_rvalid_o, data_stall_o;
   logic [7:0]    err_o;

   int n_checks = 0;
   int n_fail   = 0;

   bus_t        exp_bus[NC][$];
   logic [31:0] exp_rd[NC][$];

   logic [31:0] P_RD[4], P_WR[4], P_ST[4];
   logic [31:0] m_rd[NC], m_wr[NC];
   int          m_set[NC];
   logic [1:0]  m_err[NC];

   cgra_data_bus_ctrl #(
      .N_COL(4), .MAX_COL_REQ(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .col_start_i(col_start), .col_conf_ack_i(col_conf_ack), .col_acc_map_i(acc_map),
      .rd_ptr_i(rd_ptr), .wr_ptr_i(wr_ptr), .stride_i(stride),
      .rcs_req_i(rcs_req), .rcs_wen_i(rcs_wen), .rcs_ind_i(rcs_ind), .rcs_sext_i(rcs_sext),
      .rcs_size_i(rcs_size), .rcs_add_i(rcs_add), .rcs_wdata_i(rcs_wdata),
      .bus_req_o(bus_req_o), .bus_wen_o(bus_wen_o), .bus_add_o(bus_add_o),
      .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
      .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata),
      .rcs_rdata_o(rcs_rdata_o), .rcs_rvalid_o(rcs_rvalid_o),
      .data_stall_o(data_stall_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic int m_n(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit m_mis(input logic [31:0] a, input logic [1:0] sz);
      return (a % m_n(sz)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
      int n;
      n = m_n(sz);
      if (m_mis(a, sz)) return 4'hF;
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [1:0] sz);
      logic [31:0] r;
      int n;
      n = m_n(sz);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [31:0] d, input logic [31:0] a,
                                           input logic [1:0] sz, input bit sx);
      longint v;
      longint lim;
      int n;
      n   = m_n(sz);
      lim = longint'(1) << (8 * n);
      v   = longint'(d >> (8 * (a % 4))) & (lim - 1);
      if (sx && v >= lim / 2) v = v - lim;
      return v[31:0];
   endfunction

   task automatic model_grant(input int c, input bit rd, input bit ind, input logic [1:0] sz,
                              input bit sx, input logic [31:0] add, input logic [31:0] wd,
                              input logic [31:0] rdat, input bit expect_rd);
      logic [31:0] a;
      bus_t it;
      a      = ind ? add : (rd ? m_rd[c] : m_wr[c]);
      it.add = a & 32'hFFFF_FFFC;
      it.be  = m_be(a, sz);
      it.wen = rd;
      it.wd  = m_wdata(wd, sz);
      exp_bus[c].push_back(it);
      if (rd && expect_rd) exp_rd[c].push_back(m_rdata(rdat, a, sz, sx));
      if (!ind) begin
         if (rd) m_rd[c] = m_rd[c] + P_ST[m_set[c]];
         else    m_wr[c] = m_wr[c] + P_ST[m_set[c]];
      end
      if (m_mis(a, sz)) m_err[c][0] = 1'b1;
   endtask

   task automatic model_start(input int c, input logic [3:0] acks);
      int idx;
      idx = $countones(acks);
      if (idx > 3) idx = 3;
      m_set[c] = idx;
      m_rd[c]  = P_RD[idx];
      m_wr[c]  = P_WR[idx];
      m_err[c] = 2'b00;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk_i) begin : mon
      bus_t it;
      logic [31:0] er;
      if (!rst_i) begin
         for (int c = 0; c < NC; c++) begin
            if (bus_req_o[c] && bus_gnt[c]) begin
               if (exp_bus[c].size() == 0) begin
                  chk("bus_unexpected_grant", 32'(c), 32'hFFFF_FFFF);
               end else begin
                  it = exp_bus[c].pop_front();
                  chk("bus_add", bus_add_o[32*c +: 32], it.add);
                  chk("bus_be", 32'(bus_be_o[4*c +: 4]), 32'(it.be));
                  chk("bus_wen", 32'(bus_wen_o[c]), 32'(it.wen));
                  if (!it.wen) chk("bus_wdata", bus_wdata_o[32*c +: 32], it.wd);
               end
            end
            if (rcs_rvalid_o[c]) begin
               if (exp_rd[c].size() == 0) begin
                  chk("rd_unexpected_rvalid", 32'(c), 32'hFFFF_FFFF);
               end else begin
                  er = exp_rd[c].pop_front();
                  chk("rcs_rdata", rcs_rdata_o[32*c +: 32], er);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic start(input int c, input logic [3:0] acks);
      col_start[c] = 1'b1;
      col_conf_ack = acks;
      model_start(c, acks);
      step();
      col_start[c] = 1'b0;
   endtask

   task automatic access(input int c, input bit rd, input bit ind, input logic [1:0] sz,
                         input bit sx, input logic [31:0] add, input logic [31:0] wd,
                         input int gdly, input int rdly, input logic [31:0] rdat);
      rcs_req[c] = 1'b1; rcs_wen[c] = rd; rcs_ind[c] = ind; rcs_sext[c] = sx;
      rcs_size[2*c +: 2] = sz; rcs_add[32*c +: 32] = add; rcs_wdata[32*c +: 32] = wd;
      for (int i = 0; i < gdly; i++) begin
         @(negedge clk_i);
         chk("stall_wait_gnt", 32'(data_stall_o[c]), 32'd1);
         step();
      end
      bus_gnt[c] = 1'b1;
      model_grant(c, rd, ind, sz, sx, add, wd, rdat, 1'b1);
      @(negedge clk_i);
      chk("stall_gnt_cycle", 32'(data_stall_o[c]), 32'd1);
      step();
      rcs_req[c] = 1'b0; bus_gnt[c] = 1'b0;
      if (rd) begin
         for (int i = 0; i < rdly; i++) begin
            @(negedge clk_i);
            chk("stall_wait_rvalid", 32'(data_stall_o[c]), 32'd1);
            step();
         end
         bus_rvalid[c] = 1'b1; bus_rdata[32*c +: 32] = rdat;
         @(negedge clk_i);
         chk("stall_rvalid_cycle", 32'(data_stall_o[c]), 32'd0);
         step();
         bus_rvalid[c] = 1'b0;
      end
      @(negedge clk_i);
      chk("stall_idle", 32'(data_stall_o[c]), 32'd0);
      chk("err", 32'(err_o[2*c +: 2]), 32'(m_err[c]));
      step();
   endtask

   initial begin : global_bound
      #400000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      logic [31:0] v0, v1, hv;
      for (int i = 0; i < 4; i++) begin
         P_RD[i] = 32'h100 + 32'(i) * 32'h1000;
         P_WR[i] = 32'h400 + 32'(i) * 32'h1000;
         rd_ptr[32*i +: 32] = P_RD[i];
         wr_ptr[32*i +: 32] = P_WR[i];
      end
      P_ST[0] = 32'd8; P_ST[1] = 32'd4; P_ST[2] = 32'hFFFF_FFF0; P_ST[3] = 32'd12;
      for (int i = 0; i < 4; i++) stride[32*i +: 32] = P_ST[i];
      for (int c = 0; c < NC; c++) begin
         m_rd[c] = '0; m_wr[c] = '0; m_set[c] = 0; m_err[c] = 2'b00;
      end
      acc_map = 16'b1000_0100_0010_0001;
      col_start = '0; col_conf_ack = '0;
      rcs_req = '0; rcs_wen = '0; rcs_ind = '0; rcs_sext = '0; rcs_size = '0;
      rcs_add = '0; rcs_wdata = '0; bus_gnt = '0; bus_rvalid = '0; bus_rdata = '0;
      rst_i = 1'b1;
      repeat (3) step();
      rst_i = 1'b0;

      // reset state
      @(negedge clk_i);
      chk("rst_bus_req", 32'(bus_req_o), 32'd0);
      chk("rst_bus_be", 32'(bus_be_o), 32'h0000_FFFF);
      chk("rst_bus_add0", bus_add_o[31:0], 32'd0);
      chk("rst_bus_add3", bus_add_o[127:96], 32'd0);
      chk("rst_stall", 32'(data_stall_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_rdata", rcs_rdata_o[31:0], 32'd0);
      chk("rst_rvalid", 32'(rcs_rvalid_o), 32'd0);
      step();

      // grant without request is ignored
      bus_gnt[0] = 1'b1;
      @(negedge clk_i);
      chk("stray_gnt_req", 32'(bus_req_o[0]), 32'd0);
      step();
      bus_gnt[0] = 1'b0;

      // strided reads from set 0: 0x100, 0x108, 0x110, 0x118
      start(0, 4'b0000);
      for (int i = 0; i < 4; i++) access(0, 1, 0, 2'b10, 0, 0, 0, 0, 0, 32'h1111_0000 + 32'(i));

      // indirect sign-extended byte read, byte write with replication
      access(1, 1, 1, 2'b00, 1, 32'h203, 0, 0, 0, 32'h8000_0000);
      @(negedge clk_i);
      chk("byte_sext_hold", rcs_rdata_o[63:32], 32'hFFFF_FF80);
      step();
      access(1, 0, 1, 2'b00, 0, 32'h201, 32'h0000_005A, 0, 0, 0);

      // misaligned half write, cleared by start
      access(1, 0, 1, 2'b01, 0, 32'h301, 32'h0000_BEEF, 1, 0, 0);
      chk("mis_err_set", 32'(err_o[2]), 32'd1);
      start(1, 4'b0000);
      @(negedge clk_i);
      chk("mis_err_clear", 32'(err_o[3:2]), 32'd0);
      step();

      // grouped stall: col0/col1 share a group, col1 grant delayed 3 cycles
      acc_map[3:0] = 4'b0011; acc_map[7:4] = 4'b0011;
      v0 = 32'hA5A5_0001; v1 = 32'h7E00_1234;
      rcs_req[1:0] = 2'b11; rcs_wen[1:0] = 2'b11; rcs_ind[1:0] = 2'b10; rcs_sext[1:0] = 2'b00;
      rcs_size[3:0] = 4'b1010; rcs_add[63:32] = 32'h500;
      bus_gnt[0] = 1'b1;
      model_grant(0, 1, 0, 2'b10, 0, 0, 0, v0, 1);
      for (int cyc = 0; cyc < 5; cyc++) begin
         if (cyc == 1) begin
            rcs_req[0] = 1'b0; bus_gnt[0] = 1'b0;
            bus_rvalid[0] = 1'b1; bus_rdata[31:0] = v0;
         end
         if (cyc == 2) bus_rvalid[0] = 1'b0;
         if (cyc == 3) begin
            bus_gnt[1] = 1'b1;
            model_grant(1, 1, 1, 2'b10, 0, 32'h500, 0, v1, 1);
         end
         if (cyc == 4) begin
            rcs_req[1] = 1'b0; bus_gnt[1] = 1'b0;
            bus_rvalid[1] = 1'b1; bus_rdata[63:32] = v1;
         end
         @(negedge clk_i);
         chk("group_stall0", 32'(data_stall_o[0]), (cyc < 4) ? 32'd1 : 32'd0);
         chk("group_stall1", 32'(data_stall_o[1]), (cyc < 4) ? 32'd1 : 32'd0);
         step();
      end
      bus_rvalid[1] = 1'b0;
      @(negedge clk_i);
      chk("group_hold0", rcs_rdata_o[31:0], v0);
      chk("group_hold1", rcs_rdata_o[63:32], v1);
      step();
      acc_map = 16'b1000_0100_0010_0001;

      // pointer-set select and start-over-increment priority
      start(2, 4'b0101);
      access(2, 1, 0, 2'b10, 0, 0, 0, 0, 1, 32'h0BAD_F00D);
      rcs_req[2] = 1'b1; rcs_wen[2] = 1'b1; rcs_ind[2] = 1'b0; rcs_size[5:4] = 2'b10;
      bus_gnt[2] = 1'b1; col_start[2] = 1'b1; col_conf_ack = 4'b0001;
      model_grant(2, 1, 0, 2'b10, 0, 0, 0, 32'hCAFE_F00D, 1);
      model_start(2, 4'b0001);
      step();
      rcs_req[2] = 1'b0; bus_gnt[2] = 1'b0; col_start[2] = 1'b0;
      bus_rvalid[2] = 1'b1; bus_rdata[95:64] = 32'hCAFE_F00D;
      step();
      bus_rvalid[2] = 1'b0;
      access(2, 1, 0, 2'b01, 1, 0, 0, 2, 0, 32'h0000_8001);
      start(2, 4'b1111);
      access(2, 0, 0, 2'b10, 0, 0, 32'h1234_5678, 0, 0, 0);

      // random traffic
      for (int it = 0; it < 80; it++) begin
         int c;
         bit rd, ind, sx;
         logic [1:0] sz;
         logic [31:0] add;
         c   = int'($urandom_range(0, 3));
         rd  = 1'($urandom_range(0, 1));
         ind = 1'($urandom_range(0, 1));
         sx  = 1'($urandom_range(0, 1));
         sz  = 2'($urandom_range(0, 3));
         add = $urandom;
         if (rd) add = add & ~32'(m_n(sz) - 1);
         if ($urandom_range(0, 7) == 0) start(c, 4'($urandom_range(0, 15)));
         access(c, rd, ind, sz, sx, add, $urandom, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), $urandom);
      end

      // read watchdog on column 3
      start(3, 4'b0000);
      access(3, 1, 0, 2'b10, 0, 0, 0, 0, 0, 32'h1234_5678);
      rcs_req[3] = 1'b1; rcs_wen[3] = 1'b1; rcs_ind[3] = 1'b0; rcs_size[7:6] = 2'b10;
      bus_gnt[3] = 1'b1;
`ifdef CGRA_DBUS_TIMEOUT_EN
      model_grant(3, 1, 0, 2'b10, 0, 0, 0, 0, 0);
`else
      model_grant(3, 1, 0, 2'b10, 0, 0, 0, 32'h0F0F_0F0F, 1);
`endif
      step();
      rcs_req[3] = 1'b0; bus_gnt[3] = 1'b0;
`ifdef CGRA_DBUS_TIMEOUT_EN
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk_i);
         chk("wdog_stall", 32'(data_stall_o[3]), (i < 4) ? 32'd1 : 32'd0);
         step();
      end
      @(negedge clk_i);
      chk("wdog_err", 32'(err_o[7:6]), 32'd2);
      chk("wdog_hold_cleared", rcs_rdata_o[127:96], 32'd0);
      step();
`else
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         chk("nowdog_stall_held", 32'(data_stall_o[3]), 32'd1);
         step();
      end
      bus_rvalid[3] = 1'b1; bus_rdata[127:96] = 32'h0F0F_0F0F;
      @(negedge clk_i);
      chk("nowdog_release", 32'(data_stall_o[3]), 32'd0);
      step();
      bus_rvalid[3] = 1'b0;
      @(negedge clk_i);
      chk("nowdog_err", 32'(err_o[7:6]), 32'(m_err[3]));
      chk("nowdog_hold", rcs_rdata_o[127:96], 32'h0F0F_0F0F);
      step();
`endif

      repeat (2) step();
      for (int c = 0; c < NC; c++) begin
         chk("bus_queue_drained", 32'(exp_bus[c].size()), 32'd0);
         chk("rd_queue_drained", 32'(exp_rd[c].size()), 32'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
